// File: rtl/executor_jp_io_seq_pkg.sv
// Shared definitions for the JP / IN / OUT execution sequencer and its
// condition-code evaluator.
package executor_jp_io_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_FETCH_HI = 3'd2,
        ST_FETCH_N  = 3'd3,
        ST_IO_CYC   = 3'd4,
        ST_FINISH   = 3'd5
    } state_t;

    // Latched operation
    typedef enum logic [1:0] {
        OP_JP   = 2'd0,
        OP_JPCC = 2'd1,
        OP_IN   = 2'd2,
        OP_OUT  = 2'd3
    } op_t;

    // Condition-code indices (index k of the JP cc,nn strobe)
    localparam logic [2:0] CC_NZ = 3'd0;
    localparam logic [2:0] CC_Z  = 3'd1;
    localparam logic [2:0] CC_NC = 3'd2;
    localparam logic [2:0] CC_C  = 3'd3;
    localparam logic [2:0] CC_PO = 3'd4;
    localparam logic [2:0] CC_PE = 3'd5;
    localparam logic [2:0] CC_P  = 3'd6;
    localparam logic [2:0] CC_M  = 3'd7;

    // Flag bit positions inside F
    localparam int F_S  = 7;
    localparam int F_Z  = 6;
    localparam int F_PV = 2;
    localparam int F_C  = 0;

    // Strobe vector layout: {OUT, IN, JPcc[7:0], JPnn}
    localparam int NUM_STROBES = 11;

    // Jump operations fetch two operand bytes, I/O operations fetch one
    function automatic logic op_is_jump(input op_t op);
        return (op == OP_JP) || (op == OP_JPCC);
    endfunction

endpackage

// File: rtl/executor_cc_eval.sv
// Condition-code evaluator: decides whether a conditional transfer is taken
// from the 3-bit cc field and the flag register.
module executor_cc_eval
    import executor_jp_io_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        cc_i,
    input  logic [DATA_W-1:0] f_i,
    output logic              taken_o
);

    logic flag_sel;
    logic unused_f;

    // Only S, Z, P/V and C participate; the remaining bits are deliberately ignored.
    assign unused_f = ^f_i;

    // cc[2:1] selects the flag, cc[0] selects the polarity that means "taken".
    always_comb begin
        flag_sel = 1'b0;
        unique case (cc_i[2:1])
            2'b00:   flag_sel = f_i[F_Z];
            2'b01:   flag_sel = f_i[F_C];
            2'b10:   flag_sel = f_i[F_PV];
            default: flag_sel = f_i[F_S];
        endcase
        taken_o = (flag_sel == cc_i[0]);
    end

endmodule

// File: rtl/executor_jp_io_seq.sv
// Execution sequencer for JP nn, JP cc,nn, IN A,(n) and OUT (n),A.
// Fetches operand bytes, evaluates the condition, runs the I/O cycle and
// returns the new PC (and A for IN) as one-cycle load pulses.
module executor_jp_io_seq
    import executor_jp_io_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              P2_Set_IJPnn_0,
    input  logic [7:0]        P2_Set_IJPccnn_k_0,
    input  logic              P2_Set_IOUTlnlA,
    input  logic              P2_Set_IINAlnl,
    input  logic [ADDR_W-1:0] PC,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] F,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic              IoReq,
    output logic              IoWr,
    output logic [ADDR_W-1:0] IoAddr,
    output logic [DATA_W-1:0] IoWData,
    input  logic              IoAck,
    input  logic [DATA_W-1:0] IoRData,
    output logic              Busy,
    output logic              PcLoad,
    output logic [ADDR_W-1:0] PcValue,
    output logic              ALoad,
    output logic [DATA_W-1:0] AValue,
    output logic              Done,
    output logic              Err
);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [2:0]        cc_q, cc_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] f_q, f_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] n_q, n_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              err_q, err_d;

    logic [NUM_STROBES-1:0] strobe_vec;
    logic [3:0]             strobe_cnt;
    logic [2:0]             cc_terms [8];
    logic [2:0]             dec_cc;
    op_t                    dec_op;
    logic                   cc_taken;
    logic [ADDR_W-1:0]      jump_target;
    logic [ADDR_W-1:0]      io_addr_full;

    assign strobe_vec = {P2_Set_IOUTlnlA, P2_Set_IINAlnl, P2_Set_IJPccnn_k_0, P2_Set_IJPnn_0};

    // Each cc strobe contributes its own index; at most one is high when accepted.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cc_term
            assign cc_terms[gi] = {3{P2_Set_IJPccnn_k_0[gi]}} & 3'(gi);
        end
    endgenerate

    // Count active strobes so legal (exactly one) and illegal (two or more) cases can be told apart.
    always_comb begin
        strobe_cnt = '0;
        for (int i = 0; i < NUM_STROBES; i++) begin
            strobe_cnt = strobe_cnt + 4'(strobe_vec[i]);
        end
    end

    // Encode the single active strobe into an operation and condition code.
    always_comb begin
        dec_cc = '0;
        for (int i = 0; i < 8; i++) begin
            dec_cc = dec_cc | cc_terms[i];
        end
        if (P2_Set_IJPnn_0) begin
            dec_op = OP_JP;
        end else if (|P2_Set_IJPccnn_k_0) begin
            dec_op = OP_JPCC;
        end else if (P2_Set_IINAlnl) begin
            dec_op = OP_IN;
        end else begin
            dec_op = OP_OUT;
        end
    end

    executor_cc_eval #(
        .DATA_W (DATA_W)
    ) u_cc_eval (
        .cc_i    (cc_q),
        .f_i     (f_q),
        .taken_o (cc_taken)
    );

    assign jump_target  = ADDR_W'({hi_q, lo_q});
    assign io_addr_full = ADDR_W'({a_q, n_q});

    // Next-state and datapath update; outputs decoded from registered state.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cc_d      = cc_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        f_d       = f_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        n_d       = n_q;
        in_data_d = in_data_q;
        err_d     = 1'b0;

        MemReq  = 1'b0;
        MemAddr = '0;
        IoReq   = 1'b0;
        IoWr    = 1'b0;
        IoAddr  = '0;
        IoWData = '0;
        PcLoad  = 1'b0;
        PcValue = '0;
        ALoad   = 1'b0;
        AValue  = '0;
        Done    = err_q;
        Err     = err_q;
        Busy    = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (strobe_cnt == 4'd1) begin
                    op_d    = dec_op;
                    cc_d    = dec_cc;
                    ptr_d   = PC;
                    a_d     = A;
                    f_d     = F;
                    state_d = op_is_jump(dec_op) ? ST_FETCH_LO : ST_FETCH_N;
                end else if (strobe_cnt > 4'd1) begin
                    err_d = 1'b1;
                end
            end
            ST_FETCH_LO: begin
                MemReq  = 1'b1;
                MemAddr = ptr_q;
                if (MemAck) begin
                    lo_d    = MemRData;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = ST_FETCH_HI;
                end
            end
            ST_FETCH_HI: begin
                MemReq  = 1'b1;
                MemAddr = ptr_q;
                if (MemAck) begin
                    hi_d    = MemRData;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = ST_FINISH;
                end
            end
            ST_FETCH_N: begin
                MemReq  = 1'b1;
                MemAddr = ptr_q;
                if (MemAck) begin
                    n_d     = MemRData;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = ST_IO_CYC;
                end
            end
            ST_IO_CYC: begin
                IoReq   = 1'b1;
                IoWr    = (op_q == OP_OUT);
                IoAddr  = io_addr_full;
                IoWData = a_q;
                if (IoAck) begin
                    if (op_q == OP_IN) begin
                        in_data_d = IoRData;
                    end
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                Done   = 1'b1;
                PcLoad = 1'b1;
                if ((op_q == OP_JP) || ((op_q == OP_JPCC) && cc_taken)) begin
                    PcValue = jump_target;
                end else begin
                    PcValue = ptr_q;
                end
                if (op_q == OP_IN) begin
                    ALoad  = 1'b1;
                    AValue = in_data_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_JP;
            cc_q      <= '0;
            ptr_q     <= '0;
            a_q       <= '0;
            f_q       <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            n_q       <= '0;
            in_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cc_q      <= cc_d;
            ptr_q     <= ptr_d;
            a_q       <= a_d;
            f_q       <= f_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            n_q       <= n_d;
            in_data_q <= in_data_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_executor_jp_io_seq.sv
// Directed bench for the JP / IN / OUT execution sequencer.
module tb_executor_jp_io_seq;

    logic        clock;
    logic        reset;
    logic        P2_Set_IJPnn_0;
    logic [7:0]  P2_Set_IJPccnn_k_0;
    logic        P2_Set_IOUTlnlA;
    logic        P2_Set_IINAlnl;
    logic [15:0] PC;
    logic [7:0]  A;
    logic [7:0]  F;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck;
    logic [7:0]  MemRData;
    logic        IoReq;
    logic        IoWr;
    logic [15:0] IoAddr;
    logic [7:0]  IoWData;
    logic        IoAck;
    logic [7:0]  IoRData;
    logic        Busy;
    logic        PcLoad;
    logic [15:0] PcValue;
    logic        ALoad;
    logic [7:0]  AValue;
    logic        Done;
    logic        Err;

    int n_vec;
    int n_miss;

    logic [7:0] mem [0:65535];
    logic [7:0] io_rdata;

    // Per-operation observations
    int          res_done_cycle, res_pc_cycle, res_pcload_cnt, res_first_mem;
    int          res_memreq_cycles, res_ioreq_cycles, res_nfetch, res_io_acks;
    logic [15:0] res_pc_val, res_io_addr;
    logic [15:0] res_fetch_addr [4];
    logic        res_aload_seen, res_err_seen, res_io_wr, res_timeout;
    logic [7:0]  res_aval, res_io_wdata;
    logic        res_post_done, res_post_busy;

    executor_jp_io_seq #(.ADDR_W(16), .DATA_W(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .P2_Set_IJPnn_0     (P2_Set_IJPnn_0),
        .P2_Set_IJPccnn_k_0 (P2_Set_IJPccnn_k_0),
        .P2_Set_IOUTlnlA    (P2_Set_IOUTlnlA),
        .P2_Set_IINAlnl     (P2_Set_IINAlnl),
        .PC                 (PC),
        .A                  (A),
        .F                  (F),
        .MemReq             (MemReq),
        .MemAddr            (MemAddr),
        .MemAck             (MemAck),
        .MemRData           (MemRData),
        .IoReq              (IoReq),
        .IoWr               (IoWr),
        .IoAddr             (IoAddr),
        .IoWData            (IoWData),
        .IoAck              (IoAck),
        .IoRData            (IoRData),
        .Busy               (Busy),
        .PcLoad             (PcLoad),
        .PcValue            (PcValue),
        .ALoad              (ALoad),
        .AValue             (AValue),
        .Done               (Done),
        .Err                (Err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_strobes();
        P2_Set_IJPnn_0     = 1'b0;
        P2_Set_IJPccnn_k_0 = 8'h00;
        P2_Set_IOUTlnlA    = 1'b0;
        P2_Set_IINAlnl     = 1'b0;
    endtask

    // Drives one strobe set at cycle 0 (called just after a falling edge), then
    // plays memory/I-O responder cycle by cycle and records what the DUT did.
    task automatic run_op(input logic jpnn, input logic [7:0] jpcc, input logic in_s, input logic out_s,
                          input logic [15:0] pc, input logic [7:0] a, input logic [7:0] f,
                          input int mem_wait, input int io_wait, input int noise_cycle, input int max_cycles);
        int  mcnt;
        int  icnt;
        bit  finished;
        res_done_cycle = -1; res_pc_cycle = -1; res_pcload_cnt = 0; res_first_mem = -1;
        res_memreq_cycles = 0; res_ioreq_cycles = 0; res_nfetch = 0; res_io_acks = 0;
        res_pc_val = 16'h0; res_io_addr = 16'h0; res_aload_seen = 1'b0; res_err_seen = 1'b0;
        res_io_wr = 1'b0; res_timeout = 1'b0; res_aval = 8'h0; res_io_wdata = 8'h0;
        for (int i = 0; i < 4; i++) res_fetch_addr[i] = 16'h0;
        P2_Set_IJPnn_0 = jpnn; P2_Set_IJPccnn_k_0 = jpcc; P2_Set_IINAlnl = in_s; P2_Set_IOUTlnlA = out_s;
        PC = pc; A = a; F = f;
        mcnt = 0; icnt = 0; finished = 0;
        for (int c = 1; c <= max_cycles && !finished; c++) begin
            @(negedge clock);
            if (c == 1) begin
                clear_strobes();
                PC = 16'hBEEF; A = 8'h00; F = 8'hFF;
            end
            if (noise_cycle > 0 && c == noise_cycle) begin
                P2_Set_IINAlnl = 1'b1; PC = 16'hDEAD; A = 8'hEE;
            end else if (noise_cycle > 0 && c == noise_cycle + 1) begin
                P2_Set_IINAlnl = 1'b0;
            end
            if (MemReq) begin
                res_memreq_cycles++;
                if (res_first_mem < 0) res_first_mem = c;
                if (mcnt >= mem_wait) begin
                    MemAck = 1'b1; MemRData = mem[MemAddr];
                    if (res_nfetch < 4) res_fetch_addr[res_nfetch] = MemAddr;
                    res_nfetch++; mcnt = 0;
                end else begin
                    MemAck = 1'b0; MemRData = 8'hCC; mcnt++;
                end
            end else begin
                MemAck = 1'b0; MemRData = 8'hCC; mcnt = 0;
            end
            if (IoReq) begin
                res_ioreq_cycles++;
                if (icnt >= io_wait) begin
                    IoAck = 1'b1; IoRData = io_rdata;
                    res_io_addr = IoAddr; res_io_wr = IoWr; res_io_wdata = IoWData;
                    res_io_acks++; icnt = 0;
                end else begin
                    IoAck = 1'b0; IoRData = 8'h33; icnt++;
                end
            end else begin
                IoAck = 1'b0; IoRData = 8'h33; icnt = 0;
            end
            if (PcLoad) begin res_pcload_cnt++; res_pc_cycle = c; res_pc_val = PcValue; end
            if (ALoad) begin res_aload_seen = 1'b1; res_aval = AValue; end
            if (Err) res_err_seen = 1'b1;
            if (Done) begin res_done_cycle = c; finished = 1; end
        end
        if (!finished) res_timeout = 1'b1;
        @(negedge clock);
        MemAck = 1'b0; IoAck = 1'b0;
        clear_strobes();
        res_post_done = Done;
        res_post_busy = Busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_strobes();
        PC = 16'h0; A = 8'h0; F = 8'h0;
        MemAck = 1'b0; MemRData = 8'h0; IoAck = 1'b0; IoRData = 8'h0;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({MemReq, IoReq, IoWr, PcLoad, ALoad, Done, Err, Busy} !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_ctrl: got %b expected %b", {MemReq, IoReq, IoWr, PcLoad, ALoad, Done, Err, Busy}, 8'h00);
        end
        n_vec++;
        if ({MemAddr, IoAddr, PcValue} !== 48'h0) begin
            n_miss++;
            $display("FAIL reset_addr: got %h expected %h", {MemAddr, IoAddr, PcValue}, 48'h0);
        end
        n_vec++;
        if ({IoWData, AValue} !== 16'h0) begin
            n_miss++;
            $display("FAIL reset_data: got %h expected %h", {IoWData, AValue}, 16'h0);
        end
        reset = 1'b0;
        // Stray acks while idle must not start anything
        MemAck = 1'b1; IoAck = 1'b1;
        repeat (2) @(negedge clock);
        MemAck = 1'b0; IoAck = 1'b0;
        n_vec++;
        if ({MemReq, IoReq, PcLoad, Done, Busy} !== 5'b0) begin
            n_miss++;
            $display("FAIL idle_stray_ack: got %b expected %b", {MemReq, IoReq, PcLoad, Done, Busy}, 5'b0);
        end
        $display("reset: outputs idle after reset and stray acks");
    endtask

    task automatic test_jp_nn();
        mem[16'h1234] = 8'h78; mem[16'h1235] = 8'h56;
        run_op(1'b1, 8'h00, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h00, 0, 0, 0, 20);
        $display("jp_nn: pc=1234 done_cycle=%0d pcvalue=%h", res_done_cycle, res_pc_val);
        n_vec++;
        if (res_timeout !== 1'b0) begin n_miss++; $display("FAIL jp_nn timeout: got %b expected %b", res_timeout, 1'b0); end
        n_vec++;
        if (res_pc_val !== 16'h5678) begin n_miss++; $display("FAIL jp_nn pcvalue: got %h expected %h", res_pc_val, 16'h5678); end
        n_vec++;
        if (res_pc_cycle !== 3 || res_done_cycle !== 3) begin
            n_miss++; $display("FAIL jp_nn latency: got pcload %0d done %0d expected 3 3", res_pc_cycle, res_done_cycle);
        end
        n_vec++;
        if (res_first_mem !== 1 || res_memreq_cycles !== 2) begin
            n_miss++; $display("FAIL jp_nn memreq: got first %0d cycles %0d expected 1 2", res_first_mem, res_memreq_cycles);
        end
        n_vec++;
        if (res_fetch_addr[0] !== 16'h1234 || res_fetch_addr[1] !== 16'h1235) begin
            n_miss++; $display("FAIL jp_nn addrs: got %h %h expected 1234 1235", res_fetch_addr[0], res_fetch_addr[1]);
        end
        n_vec++;
        if (res_aload_seen !== 1'b0 || res_ioreq_cycles !== 0 || res_pcload_cnt !== 1) begin
            n_miss++; $display("FAIL jp_nn side: got aload %b ioreq %0d pcloads %0d expected 0 0 1", res_aload_seen, res_ioreq_cycles, res_pcload_cnt);
        end
        n_vec++;
        if (res_post_done !== 1'b0 || res_post_busy !== 1'b0) begin
            n_miss++; $display("FAIL jp_nn after: got done %b busy %b expected 0 0", res_post_done, res_post_busy);
        end
    endtask

    task automatic test_jp_cc();
        int          ks [9]    = '{0, 1, 1, 2, 3, 4, 5, 6, 7};
        logic [7:0]  fs [9]    = '{8'h00, 8'h00, 8'h40, 8'h01, 8'h01, 8'h04, 8'h04, 8'h80, 8'h00};
        logic [15:0] exps [9]  = '{16'h8000, 16'h0402, 16'h8000, 16'h0402, 16'h8000, 16'h0402, 16'h8000, 16'h0402, 16'h0402};
        logic [7:0]  strobe;
        mem[16'h0400] = 8'h00; mem[16'h0401] = 8'h80;
        for (int r = 0; r < 9; r++) begin
            strobe = 8'h01 << ks[r];
            run_op(1'b0, strobe, 1'b0, 1'b0, 16'h0400, 8'h00, fs[r], 0, 0, 0, 20);
            $display("jp_cc: k=%0d f=%h pcvalue=%h done_cycle=%0d fetches=%0d", ks[r], fs[r], res_pc_val, res_done_cycle, res_nfetch);
            n_vec++;
            if (res_pc_val !== exps[r]) begin
                n_miss++; $display("FAIL jp_cc k%0d pcvalue: got %h expected %h", ks[r], res_pc_val, exps[r]);
            end
            n_vec++;
            if (res_nfetch !== 2 || res_done_cycle !== 3 || res_pcload_cnt !== 1) begin
                n_miss++; $display("FAIL jp_cc k%0d seq: got fetches %0d done %0d pcloads %0d expected 2 3 1", ks[r], res_nfetch, res_done_cycle, res_pcload_cnt);
            end
        end
    endtask

    task automatic test_jp_m_wrap();
        mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        run_op(1'b0, 8'h80, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h80, 0, 0, 0, 20);
        $display("jp_m_wrap: pcvalue=%h addrs=%h %h", res_pc_val, res_fetch_addr[0], res_fetch_addr[1]);
        n_vec++;
        if (res_pc_val !== 16'h1234) begin n_miss++; $display("FAIL jp_m_wrap pcvalue: got %h expected %h", res_pc_val, 16'h1234); end
        n_vec++;
        if (res_fetch_addr[0] !== 16'hFFFF || res_fetch_addr[1] !== 16'h0000) begin
            n_miss++; $display("FAIL jp_m_wrap addrs: got %h %h expected ffff 0000", res_fetch_addr[0], res_fetch_addr[1]);
        end
    endtask

    task automatic test_in_out();
        mem[16'h0300] = 8'h7F;
        io_rdata = 8'hA5;
        run_op(1'b0, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h12, 8'h00, 0, 3, 0, 20);
        $display("in: ioaddr=%h iowr=%b avalue=%h pcvalue=%h done_cycle=%0d", res_io_addr, res_io_wr, res_aval, res_pc_val, res_done_cycle);
        n_vec++;
        if (res_io_addr !== 16'h127F || res_io_wr !== 1'b0) begin
            n_miss++; $display("FAIL in io: got addr %h wr %b expected 127f 0", res_io_addr, res_io_wr);
        end
        n_vec++;
        if (res_aload_seen !== 1'b1 || res_aval !== 8'hA5) begin
            n_miss++; $display("FAIL in aload: got %b %h expected 1 a5", res_aload_seen, res_aval);
        end
        n_vec++;
        if (res_pc_val !== 16'h0301 || res_done_cycle !== 6 || res_pc_cycle !== 6) begin
            n_miss++; $display("FAIL in pc: got %h done %0d pcload %0d expected 0301 6 6", res_pc_val, res_done_cycle, res_pc_cycle);
        end
        n_vec++;
        if (res_first_mem !== 1 || res_memreq_cycles !== 1 || res_ioreq_cycles !== 4) begin
            n_miss++; $display("FAIL in bus: got mem first %0d cycles %0d io cycles %0d expected 1 1 4", res_first_mem, res_memreq_cycles, res_ioreq_cycles);
        end
        mem[16'h0310] = 8'h10;
        run_op(1'b0, 8'h00, 1'b0, 1'b1, 16'h0310, 8'h3C, 8'h00, 0, 0, 0, 20);
        $display("out: ioaddr=%h iowr=%b iowdata=%h pcvalue=%h done_cycle=%0d", res_io_addr, res_io_wr, res_io_wdata, res_pc_val, res_done_cycle);
        n_vec++;
        if (res_io_addr !== 16'h3C10 || res_io_wr !== 1'b1 || res_io_wdata !== 8'h3C) begin
            n_miss++; $display("FAIL out io: got addr %h wr %b wdata %h expected 3c10 1 3c", res_io_addr, res_io_wr, res_io_wdata);
        end
        n_vec++;
        if (res_aload_seen !== 1'b0 || res_pc_val !== 16'h0311 || res_done_cycle !== 3) begin
            n_miss++; $display("FAIL out pc: got aload %b pc %h done %0d expected 0 0311 3", res_aload_seen, res_pc_val, res_done_cycle);
        end
    endtask

    task automatic test_illegal();
        run_op(1'b1, 8'h00, 1'b1, 1'b0, 16'h0500, 8'h00, 8'h00, 0, 0, 0, 6);
        $display("illegal: err=%b done_cycle=%0d memreq=%0d ioreq=%0d", res_err_seen, res_done_cycle, res_memreq_cycles, res_ioreq_cycles);
        n_vec++;
        if (res_err_seen !== 1'b1 || res_done_cycle !== 1) begin
            n_miss++; $display("FAIL illegal err: got err %b done %0d expected 1 1", res_err_seen, res_done_cycle);
        end
        n_vec++;
        if (res_memreq_cycles !== 0 || res_ioreq_cycles !== 0 || res_pcload_cnt !== 0) begin
            n_miss++; $display("FAIL illegal bus: got mem %0d io %0d pcload %0d expected 0 0 0", res_memreq_cycles, res_ioreq_cycles, res_pcload_cnt);
        end
        n_vec++;
        if (res_post_done !== 1'b0 || res_post_busy !== 1'b0) begin
            n_miss++; $display("FAIL illegal pulse: got done %b busy %b expected 0 0", res_post_done, res_post_busy);
        end
    endtask

    task automatic test_busy_strobe();
        mem[16'h0500] = 8'h11; mem[16'h0501] = 8'h22;
        run_op(1'b1, 8'h00, 1'b0, 1'b0, 16'h0500, 8'h00, 8'h00, 2, 0, 2, 30);
        $display("busy_strobe: pcvalue=%h done_cycle=%0d ioreq=%0d", res_pc_val, res_done_cycle, res_ioreq_cycles);
        n_vec++;
        if (res_pc_val !== 16'h2211 || res_done_cycle !== 7) begin
            n_miss++; $display("FAIL busy_strobe result: got %h done %0d expected 2211 7", res_pc_val, res_done_cycle);
        end
        n_vec++;
        if (res_ioreq_cycles !== 0 || res_aload_seen !== 1'b0 || res_fetch_addr[1] !== 16'h0501) begin
            n_miss++; $display("FAIL busy_strobe side: got io %0d aload %b addr1 %h expected 0 0 0501", res_ioreq_cycles, res_aload_seen, res_fetch_addr[1]);
        end
    endtask

    task automatic test_reset_mid();
        mem[16'h2000] = 8'hAA; mem[16'h2001] = 8'hBB;
        P2_Set_IJPnn_0 = 1'b1; PC = 16'h2000;
        @(negedge clock);
        clear_strobes(); PC = 16'h0000;
        MemAck = MemReq; MemRData = mem[MemAddr];
        @(negedge clock);
        MemAck = 1'b0;
        n_vec++;
        if (MemReq !== 1'b1 || MemAddr !== 16'h2001) begin
            n_miss++; $display("FAIL reset_mid fetch_hi: got req %b addr %h expected 1 2001", MemReq, MemAddr);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_vec++;
        if ({MemReq, Busy, PcLoad, Done} !== 4'b0) begin
            n_miss++; $display("FAIL reset_mid drop: got %b expected %b", {MemReq, Busy, PcLoad, Done}, 4'b0);
        end
        @(negedge clock);
        n_vec++;
        if ({MemReq, Busy, PcLoad} !== 3'b0) begin
            n_miss++; $display("FAIL reset_mid idle: got %b expected %b", {MemReq, Busy, PcLoad}, 3'b0);
        end
        run_op(1'b1, 8'h00, 1'b0, 1'b0, 16'h2000, 8'h00, 8'h00, 0, 0, 0, 20);
        $display("reset_mid: rerun pcvalue=%h done_cycle=%0d", res_pc_val, res_done_cycle);
        n_vec++;
        if (res_pc_val !== 16'hBBAA || res_done_cycle !== 3 || res_pcload_cnt !== 1) begin
            n_miss++; $display("FAIL reset_mid rerun: got %h done %0d pcloads %0d expected bbaa 3 1", res_pc_val, res_done_cycle, res_pcload_cnt);
        end
    endtask

    task automatic test_back_to_back();
        mem[16'h0600] = 8'hEF; mem[16'h0601] = 8'hBE;
        run_op(1'b1, 8'h00, 1'b0, 1'b0, 16'h0600, 8'h00, 8'h00, 1, 0, 0, 20);
        $display("back_to_back: jp pcvalue=%h done_cycle=%0d", res_pc_val, res_done_cycle);
        n_vec++;
        if (res_pc_val !== 16'hBEEF || res_done_cycle !== 5) begin
            n_miss++; $display("FAIL b2b jp: got %h done %0d expected beef 5", res_pc_val, res_done_cycle);
        end
        mem[16'h0700] = 8'h42;
        io_rdata = 8'h5A;
        run_op(1'b0, 8'h00, 1'b1, 1'b0, 16'h0700, 8'h99, 8'hC5, 0, 0, 0, 20);
        $display("back_to_back: in avalue=%h pcvalue=%h done_cycle=%0d", res_aval, res_pc_val, res_done_cycle);
        n_vec++;
        if (res_aval !== 8'h5A || res_pc_val !== 16'h0701 || res_io_addr !== 16'h9942 || res_done_cycle !== 3) begin
            n_miss++; $display("FAIL b2b in: got a %h pc %h io %h done %0d expected 5a 0701 9942 3", res_aval, res_pc_val, res_io_addr, res_done_cycle);
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        io_rdata = 8'h00;
        test_reset();
        test_jp_nn();
        test_jp_cc();
        test_jp_m_wrap();
        test_in_out();
        test_illegal();
        test_busy_strobe();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
